// File: rtl/dispatch.sv
// Rename/dispatch stage: one-entry instruction buffer between the register
// file and the ROB / reservation station / load-store buffer.
// Holds one decoded instruction, wakes its operands from the CDB, and issues
// it once the ROB and the target station can take it.
// Build option: define DISPATCH_STAT_EN to add issue/stall statistic counters.
// Opcode encodings (must match the decoder): BEQ=5 BNE=6 BLT=7 BGE=8 BLTU=9
// BGEU=10 LB=11 LH=12 LW=13 LBU=14 LHU=15 SB=16 SH=17 SW=18.
//
// state | meaning
// EMPTY | no instruction buffered
// HOLD  | one instruction buffered, waiting for ROB/station space
module dispatch #(
  parameter int DATA_W = 32,
  parameter int NICK_W = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iRF_en,
  input  logic [NAME_W-1:0] iRF_rs1_regnm,
  input  logic [NAME_W-1:0] iRF_rs2_regnm,
  input  logic [NAME_W-1:0] iRF_rd_regnm,
  input  logic [NICK_W-1:0] iRF_rs1_nick,
  input  logic [NICK_W-1:0] iRF_rs2_nick,
  input  logic [DATA_W-1:0] iRF_rs1_dt,
  input  logic [DATA_W-1:0] iRF_rs2_dt,
  input  logic [OP_W-1:0]   iRF_op,
  input  logic [ADDR_W-1:0] iRF_pc,
  input  logic [IMM_W-1:0]  iRF_imm,
  input  logic              iRF_pd,
  output logic              oIND_stall,
  input  logic              iCDB_en,
  input  logic [NICK_W-1:0] iCDB_nick,
  input  logic [DATA_W-1:0] iCDB_dt,
  input  logic              iROB_full,
  input  logic [NICK_W-1:0] iROB_nick,
  output logic              oROB_en,
  output logic [NAME_W-1:0] oROB_rd_regnm,
  output logic [OP_W-1:0]   oROB_op,
  output logic [ADDR_W-1:0] oROB_pc,
  output logic              oROB_pd,
  input  logic              iRS_full,
  input  logic              iLSB_full,
  output logic              oRS_en,
  output logic              oLSB_en,
  output logic [NICK_W-1:0] oQ1,
  output logic [NICK_W-1:0] oQ2,
  output logic [DATA_W-1:0] oV1,
  output logic [DATA_W-1:0] oV2,
  output logic [OP_W-1:0]   oOp,
  output logic [ADDR_W-1:0] oPc,
  output logic [IMM_W-1:0]  oImm,
  output logic [NICK_W-1:0] oNick,
  output logic              oRF_nick_en,
  output logic [NAME_W-1:0] oRF_nick_regnm,
  output logic [NICK_W-1:0] oRF_nick
`ifdef DISPATCH_STAT_EN
  ,
  output logic [31:0]       oStat_issued,
  output logic [31:0]       oStat_stall
`endif
);

  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LB   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LH   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LBU  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_LHU  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SB   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SH   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(18);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_nx;
  logic [NAME_W-1:0]   b_rd, b_rd_nx;
  logic [OP_W-1:0]     b_op, b_op_nx;
  logic [ADDR_W-1:0]   b_pc, b_pc_nx;
  logic [IMM_W-1:0]    b_imm, b_imm_nx;
  logic                b_pd, b_pd_nx;
  logic [NICK_W-1:0]   b_q1, b_q1_nx, b_q2, b_q2_nx;
  logic [DATA_W-1:0]   b_v1, b_v1_nx, b_v2, b_v2_nx;

  logic                holding, b_mem, b_no_rd, issue, accept, fire;
  logic                wake1, wake2;
  logic [NICK_W-1:0]   q1_w, q2_w, cap_q1, cap_q2;
  logic [DATA_W-1:0]   v1_w, v2_w, cap_v1, cap_v2;

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic no_rd_op(input logic [OP_W-1:0] op, input logic [NAME_W-1:0] rd);
    if (rd == '0) return 1'b1;
    case (op)
      OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign holding    = (state == HOLD);
  assign b_mem      = is_mem_op(b_op);
  assign b_no_rd    = no_rd_op(b_op, b_rd);
  assign issue      = rdy & holding & ~iROB_full & (b_mem ? ~iLSB_full : ~iRS_full);
  assign oIND_stall = holding & ~issue;
  assign accept     = rdy & iRF_en & ~oIND_stall;
  // A flush drops the issue that would otherwise happen this cycle.
  assign fire       = issue & ~clr;

  // Buffered operands as seen after this cycle's CDB broadcast.
  assign wake1 = rdy & iCDB_en & (b_q1 != '0) & (iCDB_nick == b_q1);
  assign wake2 = rdy & iCDB_en & (b_q2 != '0) & (iCDB_nick == b_q2);
  assign q1_w  = wake1 ? '0 : b_q1;
  assign v1_w  = wake1 ? iCDB_dt : b_v1;
  assign q2_w  = wake2 ? '0 : b_q2;
  assign v2_w  = wake2 ? iCDB_dt : b_v2;

  // Incoming operand capture: the instruction leaving this cycle renames its
  // rd before the regfile sees it, so its nick overrides the regfile copy.
  always_comb begin
    cap_q1 = iRF_rs1_nick;
    cap_v1 = iRF_rs1_dt;
    cap_q2 = iRF_rs2_nick;
    cap_v2 = iRF_rs2_dt;
    if (issue && !b_no_rd && iRF_rs1_regnm == b_rd && iRF_rs1_regnm != '0) begin
      cap_q1 = iROB_nick;
      cap_v1 = '0;
    end else if (iRF_rs1_nick != '0 && iCDB_en && iCDB_nick == iRF_rs1_nick) begin
      cap_q1 = '0;
      cap_v1 = iCDB_dt;
    end
    if (issue && !b_no_rd && iRF_rs2_regnm == b_rd && iRF_rs2_regnm != '0) begin
      cap_q2 = iROB_nick;
      cap_v2 = '0;
    end else if (iRF_rs2_nick != '0 && iCDB_en && iCDB_nick == iRF_rs2_nick) begin
      cap_q2 = '0;
      cap_v2 = iCDB_dt;
    end
  end

  // Buffer next-state: flush, accept (possibly same cycle as issue), drain, wakeup.
  always_comb begin
    state_nx = state;
    b_rd_nx  = b_rd;
    b_op_nx  = b_op;
    b_pc_nx  = b_pc;
    b_imm_nx = b_imm;
    b_pd_nx  = b_pd;
    b_q1_nx  = b_q1;
    b_v1_nx  = b_v1;
    b_q2_nx  = b_q2;
    b_v2_nx  = b_v2;
    if (clr) begin
      state_nx = EMPTY;
    end else if (accept) begin
      state_nx = HOLD;
      b_rd_nx  = iRF_rd_regnm;
      b_op_nx  = iRF_op;
      b_pc_nx  = iRF_pc;
      b_imm_nx = iRF_imm;
      b_pd_nx  = iRF_pd;
      b_q1_nx  = cap_q1;
      b_v1_nx  = cap_v1;
      b_q2_nx  = cap_q2;
      b_v2_nx  = cap_v2;
    end else if (issue) begin
      state_nx = EMPTY;
    end else if (holding) begin
      b_q1_nx = q1_w;
      b_v1_nx = v1_w;
      b_q2_nx = q2_w;
      b_v2_nx = v2_w;
    end
  end

  // State, buffer and registered issue outputs (rst is synchronous, active-low).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= EMPTY;
      b_rd           <= '0;
      b_op           <= '0;
      b_pc           <= '0;
      b_imm          <= '0;
      b_pd           <= 1'b0;
      b_q1           <= '0;
      b_v1           <= '0;
      b_q2           <= '0;
      b_v2           <= '0;
      oROB_en        <= 1'b0;
      oROB_rd_regnm  <= '0;
      oROB_op        <= '0;
      oROB_pc        <= '0;
      oROB_pd        <= 1'b0;
      oRS_en         <= 1'b0;
      oLSB_en        <= 1'b0;
      oQ1            <= '0;
      oQ2            <= '0;
      oV1            <= '0;
      oV2            <= '0;
      oOp            <= '0;
      oPc            <= '0;
      oImm           <= '0;
      oNick          <= '0;
      oRF_nick_en    <= 1'b0;
      oRF_nick_regnm <= '0;
      oRF_nick       <= '0;
    end else begin
      state          <= state_nx;
      b_rd           <= b_rd_nx;
      b_op           <= b_op_nx;
      b_pc           <= b_pc_nx;
      b_imm          <= b_imm_nx;
      b_pd           <= b_pd_nx;
      b_q1           <= b_q1_nx;
      b_v1           <= b_v1_nx;
      b_q2           <= b_q2_nx;
      b_v2           <= b_v2_nx;
      oROB_en        <= fire;
      oROB_rd_regnm  <= fire ? b_rd : '0;
      oROB_op        <= fire ? b_op : '0;
      oROB_pc        <= fire ? b_pc : '0;
      oROB_pd        <= fire & b_pd;
      oRS_en         <= fire & ~b_mem;
      oLSB_en        <= fire & b_mem;
      oQ1            <= fire ? q1_w : '0;
      oQ2            <= fire ? q2_w : '0;
      oV1            <= fire ? v1_w : '0;
      oV2            <= fire ? v2_w : '0;
      oOp            <= fire ? b_op : '0;
      oPc            <= fire ? b_pc : '0;
      oImm           <= fire ? b_imm : '0;
      oNick          <= fire ? iROB_nick : '0;
      oRF_nick_en    <= fire & ~b_no_rd;
      oRF_nick_regnm <= (fire && !b_no_rd) ? b_rd : '0;
      oRF_nick       <= (fire && !b_no_rd) ? iROB_nick : '0;
    end
  end

`ifdef DISPATCH_STAT_EN
  // Issue and stall statistics, frozen while rdy is low; wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      oStat_issued <= '0;
      oStat_stall  <= '0;
    end else if (rdy) begin
      if (fire)       oStat_issued <= oStat_issued + 32'd1;
      if (oIND_stall) oStat_stall  <= oStat_stall + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/dispatch.md
Name: dispatch

Overview:
- Rename/dispatch stage directly downstream of the register file.
- Takes one decoded instruction per cycle, with its operand values or rename nicks, and holds it in a one-entry buffer.
- While holding, tracks CDB wakeups for waiting operands.
- When the ROB and the target station have space, allocates a ROB entry, issues to the RS (ALU/branch) or LSB (load/store), and writes the new rename nick back to the register file.

Parameters:
- DATA_W, 32, operand data width
- NICK_W, 4, ROB nick width; nick 0 = "no producer, value valid"
- NAME_W, 5, architectural register index width
- OP_W, 6, internal opcode width (encodings per config.v)
- ADDR_W, 32, pc width
- IMM_W, 32, immediate width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- rdy  in  1  global ready; 0 freezes all state
- clr  in  1  flush (mispredict)
- iRF_en  in  1  instruction valid from regfile
- iRF_rs1_regnm, iRF_rs2_regnm, iRF_rd_regnm  in  NAME_W  source/dest register names
- iRF_rs1_nick, iRF_rs2_nick  in  NICK_W  source nicks
- iRF_rs1_dt, iRF_rs2_dt  in  DATA_W  source values
- iRF_op  in  OP_W;  iRF_pc  in  ADDR_W;  iRF_imm  in  IMM_W;  iRF_pd  in  1  predicted-taken
- oIND_stall  out  1  upstream must hold its instruction
- iCDB_en  in  1;  iCDB_nick  in  NICK_W;  iCDB_dt  in  DATA_W  result broadcast
- iROB_full  in  1;  iROB_nick  in  NICK_W  next free ROB nick
- oROB_en  out  1;  oROB_rd_regnm  out  NAME_W;  oROB_op  out  OP_W;  oROB_pc  out  ADDR_W;  oROB_pd  out  1
- iRS_full, iLSB_full  in  1  station has no free entry
- oRS_en, oLSB_en  out  1  issue strobes
- oQ1, oQ2  out  NICK_W;  oV1, oV2  out  DATA_W;  oOp  out  OP_W;  oPc  out  ADDR_W;  oImm  out  IMM_W;  oNick  out  NICK_W  shared payload for RS/LSB
- oRF_nick_en  out  1;  oRF_nick_regnm  out  NAME_W;  oRF_nick  out  NICK_W  rename write to regfile

Behaviour:
- Classification:
  - is_mem = op in {LB, LH, LW, LBU, LHU, SB, SH, SW}.
  - no_rd = rd == 0, or op in {SB, SH, SW, BEQ, BNE, BLT, BGE, BLTU, BGEU}.
- Buffer state machine:
  - States: EMPTY, HOLD (buf_valid).
  - issue = rdy & buf_valid & !iROB_full & (is_mem ? !iLSB_full : !iRS_full).
  - oIND_stall = buf_valid & !issue (combinational).
  - accept = rdy & iRF_en & !oIND_stall.
  - Transitions:
    - accept → HOLD
    - issue & !accept → EMPTY
    - issue & accept → stays HOLD with the new instruction (throughput 1/cycle)
  - iRF_en while stalled is ignored.
- Capture priority per source operand on accept:
  1. Same-cycle rename override: if issue & !no_rd(buffered) & rsX_regnm == buffered rd & rsX_regnm != 0, then Q = iROB_nick, V = 0.
  2. Otherwise, if nick != 0 & iCDB_en & iCDB_nick == nick, then Q = 0, V = iCDB_dt.
  3. Otherwise take the regfile values.
- Wakeup in HOLD: each rdy cycle, any operand with Q != 0 and a matching CDB gets Q = 0, V = iCDB_dt.
- Issue outputs (registered, asserted the cycle after the issue condition, one-cycle pulses):
  - oROB_en = 1.
  - oRS_en or oLSB_en = 1.
  - Payload carries the buffered fields, already CDB-updated in the issue cycle.
  - oNick = iROB_nick sampled at issue.
  - oRF_nick_en = !no_rd, with regnm = rd and nick = iROB_nick.
  - All strobes are 0 in every other cycle; payload is 0 when strobes are 0.
- clr (synchronous, outranks everything except reset): buffer → EMPTY and all strobes 0 on the next edge. The issue in the clr cycle is dropped.
- rdy = 0: state and outputs hold, no strobes regenerate (strobes forced 0), CDB ignored.
- Reset (rst = 0, any state, mid-HOLD included):
  - buf_valid = 0.
  - All outputs 0, oIND_stall = 0.
  - Counters (if built) = 0.
- Latency: an instruction accepted at edge N issues at N+1 at the earliest (strobes visible after edge N+1).

Optional Feature:
- Macro DISPATCH_STAT_EN adds two outputs:
  - oStat_issued (32b): +1 per issue.
  - oStat_stall (32b): +1 per cycle with oIND_stall = 1.
- Both counters wrap at 2^32, reset to 0 and freeze when rdy = 0.
- Without the macro: ports, counters and logic are absent; all other behaviour is identical.

Test Plan:
- ADD x3 ← x1 (nick 0, 5), x2 (nick 0, 7); ROB nick 4 free → next cycle: oRS_en = 1, oQ1 = oQ2 = 0, oV1 = 5, oV2 = 7, oNick = 4, oROB_en = 1, oRF_nick_en = 1 with regnm 3 / nick 4.
- LW with rs1 nick 2, CDB nick 2 data 0x100 in the accept cycle → oLSB_en with oQ1 = 0, oV1 = 0x100; SW with rd field 0 → no oRF_nick_en.
- iRS_full = 1 for 3 cycles with ADD buffered → oIND_stall = 1 for 3 cycles; CDB for its nick in cycle 2 is captured; issues once full drops, with Q = 0.
- Back-to-back: ADD x5 (ROB nick 6) issues while SUB x7 ← x5 is accepted with regfile nick 0 → SUB buffered with Q1 = 6 (rename override).
- clr asserted while HOLD and issue both true → no strobes next cycle, buffer empty, stall = 0.
- rst = 0 mid-HOLD → all outputs 0 next edge; with DISPATCH_STAT_EN, counters read 0.
